// File: rtl/rgmii_rx_nibble_assembler.sv
// RGMII RX nibble assembler: registered 1G pass-through, or SFD-aligned nibble-to-byte packing at 10/100
// with a clock-enable strobe, plus filtered decode of the in-band link status sent during inter-frame gap.
module rgmii_rx_nibble_assembler #(
    parameter int STATUS_FILTER = 4,
    parameter bit ENABLE_INBAND = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] m_rxd,
    output logic       m_rx_dv,
    output logic       m_rx_er,
    output logic       m_clk_en,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_change,
    output logic       frame_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA_LO,
        S_DATA_HI,
        S_DROP
    } state_t;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;
    localparam logic [3:0] FILTER  = 4'(STATUS_FILTER);

    // Frame path state
    state_t     state_q,       state_d;
    logic       toggle_q,      toggle_d;
    logic [3:0] prev_q,        prev_d;
    logic [3:0] lo_q,          lo_d;
    logic       er_lo_q,       er_lo_d;
    logic [1:0] speed_q;
    logic [7:0] m_rxd_q,       m_rxd_d;
    logic       m_rx_dv_q,     m_rx_dv_d;
    logic       m_rx_er_q,     m_rx_er_d;
    logic       m_clk_en_q,    m_clk_en_d;
    logic       frame_abort_q, frame_abort_d;

    // In-band status state
    logic [3:0] samp_q,          samp_d;
    logic [3:0] cnt_q,           cnt_d;
    logic       link_up_q,       link_up_d;
    logic [1:0] link_speed_q,    link_speed_d;
    logic       full_duplex_q,   full_duplex_d;
    logic       status_change_q, status_change_d;

    logic [3:0] nibble;
    logic       gig_mode;
    logic       speed_changed;

    assign nibble        = gmii_rxd[3:0];
    assign gig_mode      = speed[1];
    assign speed_changed = (speed != speed_q);

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        toggle_d      = toggle_q;
        prev_d        = prev_q;
        lo_d          = lo_q;
        er_lo_d       = er_lo_q;
        m_rxd_d       = m_rxd_q;
        m_rx_dv_d     = 1'b0;
        m_rx_er_d     = 1'b0;
        m_clk_en_d    = 1'b0;
        frame_abort_d = 1'b0;

        if (speed_changed && (state_q != S_IDLE)) begin
            // A rate switch inside a frame leaves a half-built byte; close the frame with an error.
            m_clk_en_d    = 1'b1;
            m_rx_er_d     = 1'b1;
            frame_abort_d = 1'b1;
            state_d       = S_DROP;
        end else if (gig_mode) begin
            m_rxd_d    = gmii_rxd;
            m_rx_dv_d  = gmii_rx_dv;
            m_rx_er_d  = gmii_rx_er;
            m_clk_en_d = 1'b1;
            state_d    = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    toggle_d   = ~toggle_q;
                    m_clk_en_d = ~toggle_q;
                    if (gmii_rx_dv) begin
                        prev_d  = nibble;
                        state_d = S_PREAMBLE;
                    end
                end

                S_PREAMBLE: begin
                    prev_d = nibble;
                    if (!gmii_rx_dv) begin
                        state_d = S_IDLE;
                    end else if (nibble == NIB_PRE) begin
                        state_d = S_PREAMBLE;
                    end else if ((nibble == NIB_SFD) && (prev_q == NIB_PRE)) begin
                        m_rxd_d    = {NIB_SFD, NIB_PRE};
                        m_rx_dv_d  = 1'b1;
                        m_clk_en_d = 1'b1;
                        state_d    = S_DATA_LO;
                    end else begin
                        frame_abort_d = 1'b1;
                        state_d       = S_DROP;
                    end
                end

                S_DATA_LO: begin
                    if (!gmii_rx_dv) begin
                        m_clk_en_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        lo_d    = nibble;
                        er_lo_d = gmii_rx_er;
                        state_d = S_DATA_HI;
                    end
                end

                S_DATA_HI: begin
                    m_clk_en_d = 1'b1;
                    if (!gmii_rx_dv) begin
                        // Odd nibble count: the low half has no partner, so flag the frame as bad.
                        m_rx_er_d     = 1'b1;
                        frame_abort_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        m_rxd_d   = {nibble, lo_q};
                        m_rx_dv_d = 1'b1;
                        m_rx_er_d = er_lo_q | gmii_rx_er;
                        state_d   = S_DATA_LO;
                    end
                end

                S_DROP: begin
                    toggle_d   = ~toggle_q;
                    m_clk_en_d = ~toggle_q;
                    if (!gmii_rx_dv) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    logic       stat_valid;
    logic [3:0] stat_now;

    assign stat_valid = ENABLE_INBAND && !gmii_rx_dv && !gmii_rx_er;
    assign stat_now   = {full_duplex_q, link_speed_q, link_up_q};

    always_comb begin
        samp_d          = samp_q;
        cnt_d           = cnt_q;
        link_up_d       = link_up_q;
        link_speed_d    = link_speed_q;
        full_duplex_d   = full_duplex_q;
        status_change_d = 1'b0;

        if (!stat_valid) begin
            cnt_d = 4'd0;
        end else if ((cnt_q == 4'd0) || (nibble != samp_q)) begin
            samp_d = nibble;
            cnt_d  = 4'd1;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end

        // The count includes the current sample, so the update lands on the FILTER-th identical sample.
        if (stat_valid && (cnt_d >= FILTER) && (nibble != stat_now)) begin
            link_up_d       = nibble[0];
            link_speed_d    = nibble[2:1];
            full_duplex_d   = nibble[3];
            status_change_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            toggle_q        <= 1'b0;
            prev_q          <= 4'd0;
            lo_q            <= 4'd0;
            er_lo_q         <= 1'b0;
            speed_q         <= 2'b00;
            m_rxd_q         <= 8'd0;
            m_rx_dv_q       <= 1'b0;
            m_rx_er_q       <= 1'b0;
            m_clk_en_q      <= 1'b0;
            frame_abort_q   <= 1'b0;
            samp_q          <= 4'd0;
            cnt_q           <= 4'd0;
            link_up_q       <= 1'b0;
            link_speed_q    <= 2'b00;
            full_duplex_q   <= 1'b0;
            status_change_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            toggle_q        <= toggle_d;
            prev_q          <= prev_d;
            lo_q            <= lo_d;
            er_lo_q         <= er_lo_d;
            speed_q         <= speed;
            m_rxd_q         <= m_rxd_d;
            m_rx_dv_q       <= m_rx_dv_d;
            m_rx_er_q       <= m_rx_er_d;
            m_clk_en_q      <= m_clk_en_d;
            frame_abort_q   <= frame_abort_d;
            samp_q          <= samp_d;
            cnt_q           <= cnt_d;
            link_up_q       <= link_up_d;
            link_speed_q    <= link_speed_d;
            full_duplex_q   <= full_duplex_d;
            status_change_q <= status_change_d;
        end
    end

    assign m_rxd         = m_rxd_q;
    assign m_rx_dv       = m_rx_dv_q;
    assign m_rx_er       = m_rx_er_q;
    assign m_clk_en      = m_clk_en_q;
    assign frame_abort   = frame_abort_q;
    assign link_up       = link_up_q;
    assign link_speed    = link_speed_q;
    assign full_duplex   = full_duplex_q;
    assign status_change = status_change_q;

endmodule

// File: tb/tb_rgmii_rx_nibble_assembler.sv
// Directed bench: expected output beats are queued as frames are driven and popped by a negedge monitor.
module tb_rgmii_rx_nibble_assembler;

    logic       clk;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_rxd;
    logic       m_rx_dv;
    logic       m_rx_er;
    logic       m_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
    logic       status_change;
    logic       frame_abort;

    rgmii_rx_nibble_assembler #(
        .STATUS_FILTER(4),
        .ENABLE_INBAND(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .speed        (speed),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .m_rxd        (m_rxd),
        .m_rx_dv      (m_rx_dv),
        .m_rx_er      (m_rx_er),
        .m_clk_en     (m_clk_en),
        .link_up      (link_up),
        .link_speed   (link_speed),
        .full_duplex  (full_duplex),
        .status_change(status_change),
        .frame_abort  (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dv;
        logic       er;
        logic [7:0] rxd;
    } beat_t;

    beat_t      exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         abort_cnt   = 0;
    int         stat_cnt    = 0;
    logic [7:0] idle_rxd    = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic dv, input logic er, input logic [7:0] rxd);
        beat_t b;
        b.dv  = dv;
        b.er  = er;
        b.rxd = rxd;
        exp_q.push_back(b);
    endtask

    task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, idle_rxd);
    endtask

    // Monitor: every strobed beat carrying dv or er must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_abort) abort_cnt++;
            if (status_change) stat_cnt++;
            if (m_clk_en && (m_rx_dv || m_rx_er)) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_unexpected: observed dv=%0b er=%0b rxd=%0h expected no beat",
                           m_rx_dv, m_rx_er, m_rxd);
                end
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_dv", 32'(m_rx_dv), 32'(e.dv));
                    check("beat_er", 32'(m_rx_er), 32'(e.er));
                    if (e.dv) check("beat_rxd", 32'(m_rxd), 32'(e.rxd));
                end
            end
        end
    end

    int ab0;
    int sc0;

    initial begin
        rst        = 1'b1;
        speed      = 2'b01;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        #3;
        check("rst_m_rxd", 32'(m_rxd), 32'h0);
        check("rst_m_rx_dv", 32'(m_rx_dv), 32'h0);
        check("rst_m_rx_er", 32'(m_rx_er), 32'h0);
        check("rst_m_clk_en", 32'(m_clk_en), 32'h0);
        check("rst_link_up", 32'(link_up), 32'h0);
        check("rst_link_speed", 32'(link_speed), 32'h0);
        check("rst_full_duplex", 32'(full_duplex), 32'h0);
        check("rst_pulses", 32'({status_change, frame_abort}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 100M: long preamble, SFD, two data bytes, clean end of frame.
        idle(4);
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'h21);
        push(1'b1, 1'b0, 8'h43);
        repeat (15) cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b1, 1'b0, 8'h04);
        cyc(1'b0, 1'b0, idle_rxd);
        check("eof_clk_en", 32'(m_clk_en), 32'h1);
        check("eof_dv", 32'(m_rx_dv), 32'h0);
        check("eof_er", 32'(m_rx_er), 32'h0);
        idle(3);
        check("sb_drain_100m", 32'(exp_q.size()), 32'h0);

        // 10M: odd nibble count leaves a dangling nibble.
        speed = 2'b00;
        idle(2);
        ab0 = abort_cnt;
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'hBA);
        push(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h0A);
        cyc(1'b1, 1'b0, 8'h0B);
        cyc(1'b1, 1'b0, 8'h0C);
        cyc(1'b0, 1'b0, idle_rxd);
        check("dangling_abort", 32'(frame_abort), 32'h1);
        idle(3);
        check("dangling_abort_cnt", 32'(abort_cnt), 32'(ab0 + 1));
        check("sb_drain_10m", 32'(exp_q.size()), 32'h0);

        // 100M: bad preamble, rest of that frame dropped, next good frame accepted.
        speed = 2'b01;
        idle(2);
        ab0 = abort_cnt;
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h07);
        check("bad_pre_abort", 32'(frame_abort), 32'h1);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        idle(3);
        check("bad_pre_abort_cnt", 32'(abort_cnt), 32'(ab0 + 1));
        check("bad_pre_no_beats", 32'(exp_q.size()), 32'h0);
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'hFE);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h0E);
        cyc(1'b1, 1'b0, 8'h0F);
        idle(3);
        check("sb_drain_recover", 32'(exp_q.size()), 32'h0);

        // 1G: registered pass-through with permanent clock enable.
        speed = 2'b10;
        idle(2);
        check("gig_idle_clk_en", 32'(m_clk_en), 32'h1);
        push(1'b1, 1'b0, 8'h55);
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'hAB);
        cyc(1'b1, 1'b0, 8'h55);
        check("gig_latency", 32'({m_rx_dv, m_rxd}), 32'h155);
        cyc(1'b1, 1'b0, 8'hD5);
        cyc(1'b1, 1'b0, 8'hAB);
        cyc(1'b0, 1'b0, idle_rxd);
        check("gig_eof_clk_en", 32'(m_clk_en), 32'h1);
        idle(2);
        check("sb_drain_gig", 32'(exp_q.size()), 32'h0);

        // In-band status: 0xD = link up, 1G, full duplex; needs four identical idle samples.
        speed = 2'b01;
        idle(2);
        sc0 = stat_cnt;
        idle_rxd = 8'h0D;
        idle(3);
        check("status_3_samples", 32'(link_up), 32'h0);
        idle(1);
        check("status_link_up", 32'(link_up), 32'h1);
        check("status_link_speed", 32'(link_speed), 32'h2);
        check("status_full_duplex", 32'(full_duplex), 32'h1);
        idle(2);
        check("status_pulse_cnt", 32'(stat_cnt), 32'(sc0 + 1));
        repeat (3) cyc(1'b0, 1'b0, 8'h02);
        cyc(1'b0, 1'b0, 8'h06);
        idle(3);
        check("status_hold_link", 32'(link_up), 32'h1);
        check("status_hold_speed", 32'(link_speed), 32'h2);
        check("status_hold_pulses", 32'(stat_cnt), 32'(sc0 + 1));

        // Speed change 100M -> 10M in the middle of frame data.
        idle(2);
        ab0 = abort_cnt;
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'h21);
        push(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        speed = 2'b00;
        cyc(1'b1, 1'b0, 8'h03);
        check("spdchg_abort", 32'(frame_abort), 32'h1);
        cyc(1'b1, 1'b0, 8'h04);
        idle(3);
        check("spdchg_abort_cnt", 32'(abort_cnt), 32'(ab0 + 1));
        check("sb_drain_spdchg", 32'(exp_q.size()), 32'h0);

        // Async reset mid-frame: everything clears at once, leftover nibbles cannot form bytes.
        speed = 2'b01;
        idle(2);
        push(1'b1, 1'b0, 8'hD5);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("arst_outputs", 32'({m_rxd, m_rx_dv, m_rx_er, m_clk_en}), 32'h0);
        check("arst_status", 32'({link_up, link_speed, full_duplex}), 32'h0);
        check("arst_pulses", 32'({status_change, frame_abort}), 32'h0);
        idle_rxd   = 8'h00;
        gmii_rx_dv = 1'b1;
        gmii_rxd   = 8'h02;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ab0 = abort_cnt;
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b1, 1'b0, 8'h04);
        idle(3);
        check("arst_no_sfd_abort", 32'(abort_cnt), 32'(ab0 + 1));
        push(1'b1, 1'b0, 8'hD5);
        push(1'b1, 1'b0, 8'h87);
        cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b0, 8'h0D);
        cyc(1'b1, 1'b0, 8'h07);
        cyc(1'b1, 1'b0, 8'h08);
        idle(3);
        check("sb_final", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
